// File: rtl/step_clock_conditioner.sv
// Conditions a bouncing push button and run/step switch into a glitch-free,
// single-stepped or free-running CPU clock with an edge counter.
module step_clock_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
  parameter int unsigned HOLD_CYCLES     = 32'd50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_in,
  input  logic        run_sw,
  output logic        btn_level,
  output logic        run_level,
  output logic        step_pulse,
  output logic        step_clk,
  output logic        busy,
  output logic [15:0] step_count
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned PW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [PW-1:0] PH_LAST = PW'(HOLD_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Bit 0 carries the button, bit 1 the run switch.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    level_q, level_d;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];
  logic          btn_prev_q;
  logic          step_pulse_q, step_pulse_d;
  state_t        state_q;
  logic [PW-1:0] phase_q;
  logic          step_clk_q, busy_q;
  logic [15:0]   step_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {run_sw, btn_in};
      sync2_q <= sync1_q;
    end
  end

  // A level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d     = level_q;
    db_cnt_d[0] = '0;
    db_cnt_d[1] = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i]  = ~level_q[i];
          db_cnt_d[i] = '0;
        end else begin
          level_d[i]  = level_q[i];
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end else begin
        level_d[i]  = level_q[i];
        db_cnt_d[i] = '0;
      end
    end
  end

  // Presses arriving outside IDLE or in run mode are dropped, never queued.
  always_comb begin
    step_pulse_d = level_q[0] & ~btn_prev_q & ~level_q[1] & (state_q == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q      <= 2'b00;
      db_cnt_q[0]  <= '0;
      db_cnt_q[1]  <= '0;
      btn_prev_q   <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      level_q      <= level_d;
      db_cnt_q[0]  <= db_cnt_d[0];
      db_cnt_q[1]  <= db_cnt_d[1];
      btn_prev_q   <= level_q[0];
      step_pulse_q <= step_pulse_d;
    end
  end

  // Phases always run to completion; run_level is only sampled at IDLE and end of LOW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      step_clk_q   <= 1'b0;
      busy_q       <= 1'b0;
      step_count_q <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          phase_q <= '0;
          if (step_pulse_q || level_q[1]) begin
            state_q      <= HIGH;
            step_clk_q   <= 1'b1;
            busy_q       <= 1'b1;
            step_count_q <= step_count_q + 16'd1;
          end else begin
            state_q    <= IDLE;
            step_clk_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        HIGH: begin
          busy_q <= 1'b1;
          if (phase_q == PH_LAST) begin
            state_q    <= LOW;
            phase_q    <= '0;
            step_clk_q <= 1'b0;
          end else begin
            state_q    <= HIGH;
            phase_q    <= phase_q + PW'(1);
            step_clk_q <= 1'b1;
          end
        end
        LOW: begin
          if (phase_q == PH_LAST) begin
            phase_q <= '0;
            if (level_q[1]) begin
              state_q      <= HIGH;
              step_clk_q   <= 1'b1;
              busy_q       <= 1'b1;
              step_count_q <= step_count_q + 16'd1;
            end else begin
              state_q    <= IDLE;
              step_clk_q <= 1'b0;
              busy_q     <= 1'b0;
            end
          end else begin
            state_q    <= LOW;
            phase_q    <= phase_q + PW'(1);
            step_clk_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          phase_q    <= '0;
          step_clk_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level  = level_q[0];
  assign run_level  = level_q[1];
  assign step_pulse = step_pulse_q;
  assign step_clk   = step_clk_q;
  assign busy       = busy_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_step_clock_conditioner.sv
// Bench for step_clock_conditioner: output edges are matched against a queue of
// expected (event, cycle) pairs pushed as each scenario drives its stimulus.
`timescale 1ns/1ps
module tb_step_clock_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  // Event kinds: 2*signal + (0 rise, 1 fall); signals btn, pulse, sclk, busy, run.
  localparam int K_BTN_R = 0, K_BTN_F = 1, K_PUL_R = 2, K_PUL_F = 3;
  localparam int K_CLK_R = 4, K_CLK_F = 5, K_BSY_R = 6, K_BSY_F = 7;
  localparam int K_RUN_R = 8, K_RUN_F = 9;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic        clk = 1'b0, rst = 1'b1, btn_in = 1'b0, run_sw = 1'b0;
  logic        btn_level, run_level, step_pulse, step_clk, busy;
  logic [15:0] step_count;

  logic        clk_w = 1'b0, rst_w = 1'b1, run_w = 1'b0;
  logic        btn_level_w, run_level_w, step_pulse_w, step_clk_w, busy_w;
  logic [15:0] step_count_w;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  ev_t  exp_q[$];
  logic [4:0] prev_s = 5'b0;
  logic [4:0] cur_s;

  step_clock_conditioner #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .run_sw(run_sw),
    .btn_level(btn_level), .run_level(run_level), .step_pulse(step_pulse),
    .step_clk(step_clk), .busy(busy), .step_count(step_count)
  );

  step_clock_conditioner #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(1)) dut_wrap (
    .clk(clk_w), .rst(rst_w), .btn_in(1'b0), .run_sw(run_w),
    .btn_level(btn_level_w), .run_level(run_level_w), .step_pulse(step_pulse_w),
    .step_clk(step_clk_w), .busy(busy_w), .step_count(step_count_w)
  );

  always #5 clk = ~clk;
  always #2 clk_w = ~clk_w;
  always @(posedge clk) cyc++;

  // Pops one expected event per observed output edge.
  always @(posedge clk) begin
    #2;
    cur_s = {run_level, busy, step_clk, step_pulse, btn_level};
    if (mon_en) begin
      for (int s = 0; s < 5; s++) begin
        for (int f = 0; f < 2; f++) begin
          if ((f == 0 && cur_s[s] && !prev_s[s]) || (f == 1 && !cur_s[s] && prev_s[s])) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_event: got kind=%0d at cyc=%0d, expected no event", 2*s+f, cyc);
            end else begin
              ev_t e;
              e = exp_q.pop_front();
              if (e.kind !== 2*s+f || e.cyc !== cyc) begin
                errors++;
                $display("FAIL event_order: got kind=%0d cyc=%0d, expected kind=%0d cyc=%0d",
                         2*s+f, cyc, e.kind, e.cyc);
              end
            end
          end
        end
      end
    end
    prev_s = cur_s;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic expect_ev(input int k, input int t);
    ev_t e;
    e.kind = k;
    e.cyc  = t;
    exp_q.push_back(e);
  endtask

  task automatic push_single_step(input int c);
    expect_ev(K_BTN_R, c + 6);
    expect_ev(K_PUL_R, c + 7);
    expect_ev(K_PUL_F, c + 8);
    expect_ev(K_CLK_R, c + 8);
    expect_ev(K_BSY_R, c + 8);
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    exp_q.delete();
    btn_in = 1'b0;
    run_sw = 1'b0;
    rst    = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    int r;
    btn_in = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({btn_level, run_level, step_pulse, step_clk, busy} !== 5'b0 || step_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async: got lv=%b cnt=%h, expected 00000 0000",
               {btn_level, run_level, step_pulse, step_clk, busy}, step_count);
    end
    repeat (4) tick();
    checks++;
    if ({btn_level, run_level, step_pulse, step_clk, busy} !== 5'b0 || step_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_held: got lv=%b cnt=%h, expected 00000 0000",
               {btn_level, run_level, step_pulse, step_clk, busy}, step_count);
    end
    r = cyc;
    rst = 1'b1;
    mon_en = 1'b1;
    push_single_step(r);
    expect_ev(K_CLK_F, r + 16);
    expect_ev(K_BSY_F, r + 24);
    wait_until(r + 30);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_release_events: got %0d pending, expected 0", exp_q.size());
    end
    checks++;
    if (step_count !== 16'd1) begin
      errors++;
      $display("FAIL reset_release_count: got %0d, expected 1", step_count);
    end
  endtask

  task automatic test_bounce();
    int c, f;
    apply_reset();
    c = cyc;
    for (int i = 0; i < 10; i++) begin
      btn_in = (i % 2 == 0);
      repeat (2) tick();
    end
    btn_in = 1'b1;
    f = cyc;
    push_single_step(f);
    expect_ev(K_CLK_F, f + 16);
    expect_ev(K_BSY_F, f + 24);
    wait_until(f + 30);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_events: got %0d pending, expected 0", exp_q.size());
    end
    checks++;
    if (step_count !== 16'd1 || btn_level !== 1'b1) begin
      errors++;
      $display("FAIL bounce_final: got cnt=%0d lvl=%b, expected cnt=1 lvl=1", step_count, btn_level);
    end
  endtask

  task automatic test_held();
    int c;
    apply_reset();
    c = cyc;
    btn_in = 1'b1;
    push_single_step(c);
    expect_ev(K_CLK_F, c + 16);
    expect_ev(K_BSY_F, c + 24);
    expect_ev(K_BTN_F, c + 206);
    wait_until(c + 200);
    btn_in = 1'b0;
    wait_until(c + 215);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL held_events: got %0d pending, expected 0", exp_q.size());
    end
    checks++;
    if (step_count !== 16'd1 || btn_level !== 1'b0) begin
      errors++;
      $display("FAIL held_final: got cnt=%0d lvl=%b, expected cnt=1 lvl=0", step_count, btn_level);
    end
  endtask

  task automatic test_press_during_busy();
    int c;
    apply_reset();
    c = cyc;
    btn_in = 1'b1;
    push_single_step(c);
    expect_ev(K_BTN_F, c + 16);
    expect_ev(K_CLK_F, c + 16);
    expect_ev(K_BTN_R, c + 20);
    expect_ev(K_BSY_F, c + 24);
    expect_ev(K_BTN_F, c + 36);
    wait_until(c + 10);
    btn_in = 1'b0;
    wait_until(c + 14);
    btn_in = 1'b1;
    wait_until(c + 21);
    checks++;
    if (step_clk !== 1'b0 || busy !== 1'b1 || btn_level !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_low: got clk=%b busy=%b lvl=%b, expected 0 1 1", step_clk, busy, btn_level);
    end
    wait_until(c + 30);
    btn_in = 1'b0;
    wait_until(c + 45);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_events: got %0d pending, expected 0", exp_q.size());
    end
    checks++;
    if (step_count !== 16'd1) begin
      errors++;
      $display("FAIL busy_count: got %0d, expected 1", step_count);
    end
  endtask

  task automatic test_run_mode();
    int c;
    apply_reset();
    c = cyc;
    run_sw = 1'b1;
    expect_ev(K_RUN_R, c + 6);
    expect_ev(K_CLK_R, c + 7);
    expect_ev(K_BSY_R, c + 7);
    for (int k = 0; k < 3; k++) begin
      expect_ev(K_CLK_F, c + 15 + 16*k);
      expect_ev(K_CLK_R, c + 23 + 16*k);
    end
    expect_ev(K_CLK_F, c + 63);
    expect_ev(K_RUN_F, c + 63);
    expect_ev(K_BSY_F, c + 71);
    wait_until(c + 7);
    checks++;
    if (step_count !== 16'd1) begin
      errors++;
      $display("FAIL run_count_first: got %0d, expected 1", step_count);
    end
    wait_until(c + 22);
    checks++;
    if (step_count !== 16'd1) begin
      errors++;
      $display("FAIL run_count_hold: got %0d, expected 1", step_count);
    end
    wait_until(c + 23);
    checks++;
    if (step_count !== 16'd2) begin
      errors++;
      $display("FAIL run_count_second: got %0d, expected 2", step_count);
    end
    wait_until(c + 57);
    run_sw = 1'b0;
    wait_until(c + 80);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL run_events: got %0d pending, expected 0", exp_q.size());
    end
    checks++;
    if (step_count !== 16'd4 || busy !== 1'b0 || step_clk !== 1'b0) begin
      errors++;
      $display("FAIL run_stop: got cnt=%0d busy=%b clk=%b, expected 4 0 0", step_count, busy, step_clk);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    apply_reset();
    c = cyc;
    run_sw = 1'b1;
    expect_ev(K_RUN_R, c + 6);
    expect_ev(K_CLK_R, c + 7);
    expect_ev(K_BSY_R, c + 7);
    for (int k = 0; k < 4; k++) begin
      expect_ev(K_CLK_F, c + 15 + 16*k);
      expect_ev(K_CLK_R, c + 23 + 16*k);
    end
    wait_until(c + 73);
    checks++;
    if (step_count !== 16'd5 || step_clk !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_pre: got cnt=%0d clk=%b pending=%0d, expected 5 1 0",
               step_count, step_clk, exp_q.size());
    end
    mon_en = 1'b0;
    run_sw = 1'b0;
    #3 rst = 1'b0;
    #1;
    checks++;
    if (step_clk !== 1'b0 || busy !== 1'b0 || step_count !== 16'h0000 || run_level !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: got clk=%b busy=%b cnt=%h run=%b, expected 0 0 0000 0",
               step_clk, busy, step_count, run_level);
    end
    repeat (2) tick();
    rst = 1'b1;
    repeat (30) tick();
    checks++;
    if (step_clk !== 1'b0 || busy !== 1'b0 || step_count !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_idle: got clk=%b busy=%b cnt=%h, expected 0 0 0000", step_clk, busy, step_count);
    end
  endtask

  task automatic test_wrap();
    int   edges;
    bit   done;
    logic prev_clk;
    edges    = 0;
    done     = 1'b0;
    prev_clk = 1'b0;
    @(posedge clk_w);
    #1 rst_w = 1'b0;
    repeat (2) @(posedge clk_w);
    #1;
    rst_w = 1'b1;
    run_w = 1'b1;
    for (int i = 0; i < 140000 && !done; i++) begin
      @(posedge clk_w);
      #1;
      if (step_clk_w && !prev_clk) begin
        edges++;
        if (edges == 65535) begin
          checks++;
          if (step_count_w !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_ffff: got %h, expected ffff", step_count_w);
          end
        end else if (edges == 65536) begin
          checks++;
          if (step_count_w !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: got %h, expected 0000", step_count_w);
          end
        end else if (edges == 65537) begin
          checks++;
          if (step_count_w !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_one: got %h, expected 0001", step_count_w);
          end
          done = 1'b1;
        end
      end
      prev_clk = step_clk_w;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wrap_timeout: got %0d edges, expected 65537", edges);
    end
    run_w = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_held();
    test_press_during_busy();
    test_run_mode();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
